// File: rtl/fft_pkg.sv
// Shared FFT helpers: lane count, base-4 digit count and base-4 digit reversal.
// Used by the output reorder buffer and available to the twiddle/stage units.
package fft_pkg;

    localparam int LANES = 4;

    // Number of base-4 digits needed to index n points (n a power of 4).
    function automatic int clog4(input int n);
        int c;
        int v;
        c = 0;
        v = n;
        while (v > 1) begin
            v = v / 4;
            c = c + 1;
        end
        return c;
    endfunction

    // Reverse the d low base-4 digits of idx.
    function automatic int unsigned digit_rev4(input int unsigned idx, input int d);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = idx;
        for (int i = 0; i < d; i++) begin
            r = (r << 2) | (v & 32'd3);
            v = v >> 2;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_output_reorder_if.sv
// 4-lane complex beat bus between the last SDF stage, the reorder buffer and the consumer.
// slave is the reorder buffer's view; master is the surrounding environment's view.
interface fft_output_reorder_if #(
    parameter int WIDTH = 32
);
    logic             input_en;
    logic [WIDTH-1:0] input_real_0;
    logic [WIDTH-1:0] input_real_1;
    logic [WIDTH-1:0] input_real_2;
    logic [WIDTH-1:0] input_real_3;
    logic [WIDTH-1:0] input_imag_0;
    logic [WIDTH-1:0] input_imag_1;
    logic [WIDTH-1:0] input_imag_2;
    logic [WIDTH-1:0] input_imag_3;

    logic             output_en;
    logic             output_last;
    logic [WIDTH-1:0] output_real_0;
    logic [WIDTH-1:0] output_real_1;
    logic [WIDTH-1:0] output_real_2;
    logic [WIDTH-1:0] output_real_3;
    logic [WIDTH-1:0] output_imag_0;
    logic [WIDTH-1:0] output_imag_1;
    logic [WIDTH-1:0] output_imag_2;
    logic [WIDTH-1:0] output_imag_3;

    modport slave (
        input  input_en,
        input  input_real_0, input_real_1, input_real_2, input_real_3,
        input  input_imag_0, input_imag_1, input_imag_2, input_imag_3,
        output output_en, output_last,
        output output_real_0, output_real_1, output_real_2, output_real_3,
        output output_imag_0, output_imag_1, output_imag_2, output_imag_3
    );

    modport master (
        output input_en,
        output input_real_0, input_real_1, input_real_2, input_real_3,
        output input_imag_0, input_imag_1, input_imag_2, input_imag_3,
        input  output_en, output_last,
        input  output_real_0, output_real_1, output_real_2, output_real_3,
        input  output_imag_0, output_imag_1, output_imag_2, output_imag_3
    );

endinterface

// File: rtl/reorder_bank.sv
// One frame of complex samples: a 4-wide write at linear address 4*beat+lane, four async reads.
// Storage is deliberately unreset; its contents only matter once a full frame has been written.
module reorder_bank
    import fft_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 16,
    localparam int AW   = $clog2(N),
    localparam int BW   = AW - 2
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [BW-1:0]    wr_beat,
    input  logic [WIDTH-1:0] wr_real [LANES],
    input  logic [WIDTH-1:0] wr_imag [LANES],
    input  logic [AW-1:0]    rd_addr [LANES],
    output logic [WIDTH-1:0] rd_real [LANES],
    output logic [WIDTH-1:0] rd_imag [LANES]
);

    logic [WIDTH-1:0] mem_real [N];
    logic [WIDTH-1:0] mem_imag [N];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int j = 0; j < LANES; j++) begin
                mem_real[{wr_beat, 2'(j)}] <= wr_real[j];
                mem_imag[{wr_beat, 2'(j)}] <= wr_imag[j];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            rd_real[j] = mem_real[rd_addr[j]];
            rd_imag[j] = mem_imag[rd_addr[j]];
        end
    end

endmodule

// File: rtl/fft_output_reorder.sv
// Ping-pong frame buffer turning base-4 digit-reversed 4-lane FFT output into natural order.
// Readout starts one edge after the last input beat and drains B beats with no backpressure.
module fft_output_reorder
    import fft_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int Num_of_samples = 16
) (
    input logic               clock,
    input logic               reset,
    fft_output_reorder_if.slave bus
);

    localparam int D  = clog4(Num_of_samples);
    localparam int B  = Num_of_samples / 4;
    localparam int CW = $clog2(B);
    localparam int AW = $clog2(Num_of_samples);

    generate
        if (Num_of_samples < 16 || (4 ** D) != Num_of_samples) begin : g_bad_size
            $error("fft_output_reorder: Num_of_samples must be a power of 4, at least 16");
        end
    endgenerate

    logic [CW-1:0]    wr_cnt;
    logic [CW-1:0]    rd_cnt;
    logic             wr_bank;
    logic             read_active;
    logic             frame_done;

    logic [WIDTH-1:0] in_real  [LANES];
    logic [WIDTH-1:0] in_imag  [LANES];
    logic [AW-1:0]    rd_addr  [LANES];
    logic [WIDTH-1:0] b0_real  [LANES];
    logic [WIDTH-1:0] b0_imag  [LANES];
    logic [WIDTH-1:0] b1_real  [LANES];
    logic [WIDTH-1:0] b1_imag  [LANES];
    logic [WIDTH-1:0] sel_real [LANES];
    logic [WIDTH-1:0] sel_imag [LANES];

    assign frame_done = bus.input_en && (wr_cnt == CW'(B - 1));

    always_comb begin
        in_real[0] = bus.input_real_0;
        in_real[1] = bus.input_real_1;
        in_real[2] = bus.input_real_2;
        in_real[3] = bus.input_real_3;
        in_imag[0] = bus.input_imag_0;
        in_imag[1] = bus.input_imag_1;
        in_imag[2] = bus.input_imag_2;
        in_imag[3] = bus.input_imag_3;
    end

    // The read bank is always the one not being written.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            rd_addr[j]  = AW'(digit_rev4(32'({rd_cnt, 2'(j)}), D));
            sel_real[j] = wr_bank ? b0_real[j] : b1_real[j];
            sel_imag[j] = wr_bank ? b0_imag[j] : b1_imag[j];
        end
    end

    reorder_bank #(.WIDTH(WIDTH), .N(Num_of_samples)) u_bank0 (
        .clock   (clock),
        .wr_en   (bus.input_en && !wr_bank),
        .wr_beat (wr_cnt),
        .wr_real (in_real),
        .wr_imag (in_imag),
        .rd_addr (rd_addr),
        .rd_real (b0_real),
        .rd_imag (b0_imag)
    );

    reorder_bank #(.WIDTH(WIDTH), .N(Num_of_samples)) u_bank1 (
        .clock   (clock),
        .wr_en   (bus.input_en && wr_bank),
        .wr_beat (wr_cnt),
        .wr_real (in_real),
        .wr_imag (in_imag),
        .rd_addr (rd_addr),
        .rd_real (b1_real),
        .rd_imag (b1_imag)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_cnt            <= '0;
            rd_cnt            <= '0;
            wr_bank           <= 1'b0;
            read_active       <= 1'b0;
            bus.output_en     <= 1'b0;
            bus.output_last   <= 1'b0;
            bus.output_real_0 <= '0;
            bus.output_real_1 <= '0;
            bus.output_real_2 <= '0;
            bus.output_real_3 <= '0;
            bus.output_imag_0 <= '0;
            bus.output_imag_1 <= '0;
            bus.output_imag_2 <= '0;
            bus.output_imag_3 <= '0;
        end else begin
            if (bus.input_en) begin
                wr_cnt <= wr_cnt + CW'(1);
                if (frame_done) begin
                    wr_bank <= ~wr_bank;
                end
            end

            // A completed frame can only coincide with the final read beat, so it simply restarts the read.
            if (frame_done) begin
                read_active <= 1'b1;
                rd_cnt      <= '0;
            end else if (read_active) begin
                rd_cnt <= rd_cnt + CW'(1);
                if (rd_cnt == CW'(B - 1)) begin
                    read_active <= 1'b0;
                end
            end

            bus.output_en   <= read_active;
            bus.output_last <= read_active && (rd_cnt == CW'(B - 1));
            if (read_active) begin
                bus.output_real_0 <= sel_real[0];
                bus.output_real_1 <= sel_real[1];
                bus.output_real_2 <= sel_real[2];
                bus.output_real_3 <= sel_real[3];
                bus.output_imag_0 <= sel_imag[0];
                bus.output_imag_1 <= sel_imag[1];
                bus.output_imag_2 <= sel_imag[2];
                bus.output_imag_3 <= sel_imag[3];
            end
        end
    end

endmodule

// File: tb/tb_fft_output_reorder.sv
// Bench for fft_output_reorder at N=16 and N=64: captured output beats are compared
// against a digit-reversal reference model built from the frames that were sent.
module tb_fft_output_reorder;

    localparam int W = 32;

    typedef logic [3:0][W-1:0] lanes_t;
    typedef struct packed {
        int unsigned cyc;
        logic        last;
        lanes_t      re;
        lanes_t      im;
    } beat_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fft_output_reorder_if #(.WIDTH(W)) bus16 ();
    fft_output_reorder_if #(.WIDTH(W)) bus64 ();

    fft_output_reorder #(.WIDTH(W), .Num_of_samples(16)) u_dut16 (
        .clock (clock),
        .reset (reset),
        .bus   (bus16.slave)
    );

    fft_output_reorder #(.WIDTH(W), .Num_of_samples(64)) u_dut64 (
        .clock (clock),
        .reset (reset),
        .bus   (bus64.slave)
    );

    int unsigned cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    beat_t       cap16[$];
    beat_t       cap64[$];
    logic [W-1:0] src_re [4][64];
    logic [W-1:0] src_im [4][64];

    always @(posedge clock) cyc++;

    // Output recorder: every beat presented with output_en=1 is stamped with its edge number.
    always @(posedge clock) begin
        beat_t b;
        #1;
        if (bus16.output_en === 1'b1) begin
            b.cyc  = cyc;
            b.last = bus16.output_last;
            b.re   = {bus16.output_real_3, bus16.output_real_2, bus16.output_real_1, bus16.output_real_0};
            b.im   = {bus16.output_imag_3, bus16.output_imag_2, bus16.output_imag_1, bus16.output_imag_0};
            cap16.push_back(b);
        end
        if (bus64.output_en === 1'b1) begin
            b.cyc  = cyc;
            b.last = bus64.output_last;
            b.re   = {bus64.output_real_3, bus64.output_real_2, bus64.output_real_1, bus64.output_real_0};
            b.im   = {bus64.output_imag_3, bus64.output_imag_2, bus64.output_imag_1, bus64.output_imag_0};
            cap64.push_back(b);
        end
    end

    // Reference: reverse the base-4 digits of idx for an n-point frame.
    function automatic int ref_rev(input int idx, input int n);
        int r;
        int v;
        int k;
        r = 0;
        v = idx;
        k = n;
        while (k > 1) begin
            r = r * 4 + (v % 4);
            v = v / 4;
            k = k / 4;
        end
        return r;
    endfunction

    function automatic lanes_t exp_re(input int f, input int m, input int n);
        lanes_t r;
        for (int j = 0; j < 4; j++) r[j] = src_re[f][ref_rev(4 * m + j, n)];
        return r;
    endfunction

    function automatic lanes_t exp_im(input int f, input int m, input int n);
        lanes_t r;
        for (int j = 0; j < 4; j++) r[j] = src_im[f][ref_rev(4 * m + j, n)];
        return r;
    endfunction

    function automatic logic [2+8*W-1:0] snap16();
        return {bus16.output_en, bus16.output_last,
                bus16.output_real_0, bus16.output_real_1, bus16.output_real_2, bus16.output_real_3,
                bus16.output_imag_0, bus16.output_imag_1, bus16.output_imag_2, bus16.output_imag_3};
    endfunction

    function automatic logic [2+8*W-1:0] snap64();
        return {bus64.output_en, bus64.output_last,
                bus64.output_real_0, bus64.output_real_1, bus64.output_real_2, bus64.output_real_3,
                bus64.output_imag_0, bus64.output_imag_1, bus64.output_imag_2, bus64.output_imag_3};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive16(input logic en, input lanes_t re, input lanes_t im);
        bus16.input_en     = en;
        bus16.input_real_0 = re[0]; bus16.input_real_1 = re[1];
        bus16.input_real_2 = re[2]; bus16.input_real_3 = re[3];
        bus16.input_imag_0 = im[0]; bus16.input_imag_1 = im[1];
        bus16.input_imag_2 = im[2]; bus16.input_imag_3 = im[3];
        tick();
    endtask

    task automatic drive64(input logic en, input lanes_t re, input lanes_t im);
        bus64.input_en     = en;
        bus64.input_real_0 = re[0]; bus64.input_real_1 = re[1];
        bus64.input_real_2 = re[2]; bus64.input_real_3 = re[3];
        bus64.input_imag_0 = im[0]; bus64.input_imag_1 = im[1];
        bus64.input_imag_2 = im[2]; bus64.input_imag_3 = im[3];
        tick();
    endtask

    // Sends frame f of src_* to the N=16 DUT as 4 consecutive beats; returns the edge of the last beat.
    task automatic send_frame16(input int f, output int unsigned e);
        lanes_t r, i;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                r[j] = src_re[f][4 * k + j];
                i[j] = src_im[f][4 * k + j];
            end
            drive16(1'b1, r, i);
        end
        e = cyc;
        drive16(1'b0, '0, '0);
    endtask

    task automatic fill_random16(input int f);
        for (int p = 0; p < 16; p++) begin
            src_re[f][p] = $urandom;
            src_im[f][p] = $urandom;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (snap16() !== '0) begin
            errors++;
            $display("FAIL reset16: outputs=%h, required all zero", snap16());
        end
        checks++;
        if (snap64() !== '0) begin
            errors++;
            $display("FAIL reset64: outputs=%h, required all zero", snap64());
        end
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (cap16.size() != 0 || cap64.size() != 0 || bus16.output_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: beats16=%0d beats64=%0d en=%b, required none", cap16.size(), cap64.size(), bus16.output_en);
        end
    endtask

    task automatic test_single_frame();
        int unsigned e;
        cap16.delete();
        for (int p = 0; p < 16; p++) begin
            src_re[0][p] = W'(p);
            src_im[0][p] = W'(100 + p);
        end
        send_frame16(0, e);
        repeat (7) tick();
        checks++;
        if (cap16.size() != 4) begin
            errors++;
            $display("FAIL single_count: got %0d beats, required 4", cap16.size());
        end
        for (int m = 0; m < cap16.size() && m < 4; m++) begin
            checks++;
            if (cap16[m].cyc != e + 1 + m || cap16[m].last !== (m == 3) ||
                cap16[m].re !== exp_re(0, m, 16) || cap16[m].im !== exp_im(0, m, 16)) begin
                errors++;
                $display("FAIL single_beat%0d: cyc=%0d last=%b re=%h im=%h, required cyc=%0d last=%b re=%h im=%h",
                         m, cap16[m].cyc, cap16[m].last, cap16[m].re, cap16[m].im,
                         e + 1 + m, (m == 3), exp_re(0, m, 16), exp_im(0, m, 16));
            end
        end
        if (cap16.size() == 4) begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (cap16[0].re[j] !== W'(4 * j) || cap16[3].re[j] !== W'(3 + 4 * j) ||
                    cap16[0].im[j] !== W'(100 + 4 * j)) begin
                    errors++;
                    $display("FAIL transpose_lane%0d: beat0 re=%0d im=%0d beat3 re=%0d, required %0d %0d %0d",
                             j, cap16[0].re[j], cap16[0].im[j], cap16[3].re[j], 4 * j, 100 + 4 * j, 3 + 4 * j);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        lanes_t r, i;
        int unsigned e0;
        int f;
        int m;
        e0 = 0;
        cap16.delete();
        for (int fr = 0; fr < 3; fr++) begin
            for (int p = 0; p < 16; p++) begin
                src_re[fr][p] = W'(16 * fr + p);
                src_im[fr][p] = $urandom;
            end
        end
        for (int fr = 0; fr < 3; fr++) begin
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 4; j++) begin
                    r[j] = src_re[fr][4 * k + j];
                    i[j] = src_im[fr][4 * k + j];
                end
                drive16(1'b1, r, i);
                if (fr == 0 && k == 3) e0 = cyc;
            end
        end
        drive16(1'b0, '0, '0);
        repeat (12) tick();
        checks++;
        if (cap16.size() != 12) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats, required 12", cap16.size());
        end
        for (int n = 0; n < cap16.size() && n < 12; n++) begin
            f = n / 4;
            m = n % 4;
            checks++;
            if (cap16[n].cyc != e0 + 1 + n || cap16[n].last !== (m == 3) ||
                cap16[n].re !== exp_re(f, m, 16) || cap16[n].im !== exp_im(f, m, 16)) begin
                errors++;
                $display("FAIL b2b_beat%0d: cyc=%0d last=%b re=%h im=%h, required cyc=%0d last=%b re=%h im=%h",
                         n, cap16[n].cyc, cap16[n].last, cap16[n].re, cap16[n].im,
                         e0 + 1 + n, (m == 3), exp_re(f, m, 16), exp_im(f, m, 16));
            end
        end
    endtask

    task automatic test_gapped64();
        lanes_t r, i;
        int unsigned e;
        cap64.delete();
        for (int p = 0; p < 64; p++) begin
            src_re[0][p] = {16'($urandom), 16'(p)};
            src_im[0][p] = $urandom;
        end
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 4; j++) begin
                r[j] = src_re[0][4 * k + j];
                i[j] = src_im[0][4 * k + j];
            end
            drive64(1'b1, r, i);
            if (k < 15) repeat (1 + $urandom_range(0, 2)) drive64(1'b0, r, i);
        end
        e = cyc;
        drive64(1'b0, '0, '0);
        repeat (20) tick();
        checks++;
        if (cap64.size() != 16) begin
            errors++;
            $display("FAIL gap_count: got %0d beats, required 16", cap64.size());
        end
        for (int m = 0; m < cap64.size() && m < 16; m++) begin
            checks++;
            if (cap64[m].cyc != e + 1 + m || cap64[m].last !== (m == 15) ||
                cap64[m].re !== exp_re(0, m, 64) || cap64[m].im !== exp_im(0, m, 64)) begin
                errors++;
                $display("FAIL gap_beat%0d: cyc=%0d last=%b re=%h im=%h, required cyc=%0d last=%b re=%h im=%h",
                         m, cap64[m].cyc, cap64[m].last, cap64[m].re, cap64[m].im,
                         e + 1 + m, (m == 15), exp_re(0, m, 64), exp_im(0, m, 64));
            end
        end
        if (cap64.size() >= 2) begin
            checks++;
            if (cap64[0].re[1][15:0] !== 16'd16 || cap64[1].re[0][15:0] !== 16'd4 ||
                cap64[0].re[0][15:0] !== 16'd0) begin
                errors++;
                $display("FAIL gap_known_index: b0l0=%0d b0l1=%0d b1l0=%0d, required 0 16 4",
                         cap64[0].re[0][15:0], cap64[0].re[1][15:0], cap64[1].re[0][15:0]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        lanes_t r, i;
        int unsigned e;
        cap16.delete();
        for (int k = 0; k < 2; k++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            i = {$urandom, $urandom, $urandom, $urandom};
            drive16(1'b1, r, i);
        end
        bus16.input_en = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (snap16() !== '0) begin
            errors++;
            $display("FAIL midframe_reset_outputs: outputs=%h, required all zero", snap16());
        end
        repeat (2) tick();
        checks++;
        if (snap16() !== '0) begin
            errors++;
            $display("FAIL midframe_reset_held: outputs=%h, required all zero", snap16());
        end
        reset = 1'b0;
        tick();
        fill_random16(1);
        send_frame16(1, e);
        repeat (7) tick();
        checks++;
        if (cap16.size() != 4) begin
            errors++;
            $display("FAIL midframe_count: got %0d beats, required 4", cap16.size());
        end
        for (int m = 0; m < cap16.size() && m < 4; m++) begin
            checks++;
            if (cap16[m].cyc != e + 1 + m || cap16[m].re !== exp_re(1, m, 16) ||
                cap16[m].im !== exp_im(1, m, 16) || cap16[m].last !== (m == 3)) begin
                errors++;
                $display("FAIL midframe_beat%0d: cyc=%0d re=%h im=%h, required cyc=%0d re=%h im=%h",
                         m, cap16[m].cyc, cap16[m].re, cap16[m].im, e + 1 + m, exp_re(1, m, 16), exp_im(1, m, 16));
            end
        end
    endtask

    task automatic test_reset_mid_readout();
        int unsigned e;
        cap16.delete();
        fill_random16(2);
        send_frame16(2, e);
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (snap16() !== '0) begin
            errors++;
            $display("FAIL readout_reset_async: outputs=%h, required all zero", snap16());
        end
        repeat (2) tick();
        reset = 1'b0;
        repeat (6) tick();
        checks++;
        if (cap16.size() != 2) begin
            errors++;
            $display("FAIL readout_truncated: got %0d beats, required 2", cap16.size());
        end
        for (int m = 0; m < cap16.size() && m < 2; m++) begin
            checks++;
            if (cap16[m].re !== exp_re(2, m, 16) || cap16[m].im !== exp_im(2, m, 16)) begin
                errors++;
                $display("FAIL readout_pre_beat%0d: re=%h im=%h, required re=%h im=%h",
                         m, cap16[m].re, cap16[m].im, exp_re(2, m, 16), exp_im(2, m, 16));
            end
        end
        cap16.delete();
        fill_random16(3);
        send_frame16(3, e);
        repeat (7) tick();
        checks++;
        if (cap16.size() != 4) begin
            errors++;
            $display("FAIL readout_next_count: got %0d beats, required 4", cap16.size());
        end
        for (int m = 0; m < cap16.size() && m < 4; m++) begin
            checks++;
            if (cap16[m].cyc != e + 1 + m || cap16[m].re !== exp_re(3, m, 16) ||
                cap16[m].im !== exp_im(3, m, 16) || cap16[m].last !== (m == 3)) begin
                errors++;
                $display("FAIL readout_next_beat%0d: cyc=%0d re=%h im=%h, required cyc=%0d re=%h im=%h",
                         m, cap16[m].cyc, cap16[m].re, cap16[m].im, e + 1 + m, exp_re(3, m, 16), exp_im(3, m, 16));
            end
        end
    endtask

    initial begin
        bus16.input_en = 1'b0;
        bus16.input_real_0 = '0; bus16.input_real_1 = '0; bus16.input_real_2 = '0; bus16.input_real_3 = '0;
        bus16.input_imag_0 = '0; bus16.input_imag_1 = '0; bus16.input_imag_2 = '0; bus16.input_imag_3 = '0;
        bus64.input_en = 1'b0;
        bus64.input_real_0 = '0; bus64.input_real_1 = '0; bus64.input_real_2 = '0; bus64.input_real_3 = '0;
        bus64.input_imag_0 = '0; bus64.input_imag_1 = '0; bus64.input_imag_2 = '0; bus64.input_imag_3 = '0;

        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gapped64();
        test_reset_mid_frame();
        test_reset_mid_readout();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
